// File: rtl/pll_lock_supervisor.sv
// PLL reset owner: qualifies LOCK with a stability filter and timeout watchdog, retries,
// then releases downstream channel resets in a staggered order.
module pll_lock_supervisor #(
  parameter int unsigned NUM_CH              = 4,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CH_STAGGER_CYCLES   = 64,
  parameter int unsigned LOSS_FILTER         = 4,
  parameter int unsigned MAX_RETRIES         = 7,
  localparam int unsigned RW                 = $clog2(MAX_RETRIES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock_i,
  input  logic              relock_req_i,
  output logic              pll_reset_o,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic              ready_o,
  output logic              fault_o,
  output logic              lock_loss_o,
  output logic [RW-1:0]     retry_cnt_o
);

  localparam int unsigned REL_LAST = (NUM_CH - 1) * CH_STAGGER_CYCLES + 1;
  localparam int unsigned PW       = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned TW       = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned RLW      = $clog2(REL_LAST + 1);
  localparam int unsigned CW_A     = (PW > TW) ? PW : TW;
  localparam int unsigned CW       = (CW_A > RLW) ? CW_A : RLW;
  localparam int unsigned SW       = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned LW       = $clog2(LOSS_FILTER + 1);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [SW-1:0]     r_stable;
  logic [SW-1:0]     w_stable_nxt;
  logic [SW-1:0]     w_stable_step;
  logic [LW-1:0]     r_loss;
  logic [LW-1:0]     w_loss_nxt;
  logic [LW-1:0]     w_loss_step;
  logic [RW-1:0]     r_retry;
  logic [RW-1:0]     w_retry_nxt;
  logic              r_lock_meta;
  logic              r_lock_sync;
  logic              r_pll_reset;
  logic              w_pll_reset_nxt;
  logic [NUM_CH-1:0] r_ch_rst;
  logic [NUM_CH-1:0] w_ch_rst_nxt;
  logic [NUM_CH-1:0] w_rel_hit;
  logic              r_ready;
  logic              w_ready_nxt;
  logic              r_fault;
  logic              w_fault_nxt;
  logic              r_lock_loss;
  logic              w_lock_loss_nxt;

  // Saturating run-length counters of synchronised lock high / low.
  assign w_stable_step = r_lock_sync
                       ? ((r_stable == SW'(LOCK_STABLE_CYCLES)) ? r_stable : r_stable + SW'(1))
                       : '0;
  assign w_loss_step   = !r_lock_sync
                       ? ((r_loss == LW'(LOSS_FILTER)) ? r_loss : r_loss + LW'(1))
                       : '0;

  // Channel i is released on the edge after the release count reaches i*stagger.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_rel
    assign w_rel_hit[g] = (r_cnt == CW'(g * CH_STAGGER_CYCLES));
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_stable_nxt    = '0;
    w_loss_nxt      = '0;
    w_retry_nxt     = r_retry;
    w_pll_reset_nxt = r_pll_reset;
    w_ch_rst_nxt    = r_ch_rst;
    w_ready_nxt     = r_ready;
    w_fault_nxt     = r_fault;
    w_lock_loss_nxt = 1'b0;

    case (r_state)
      ST_PLL_RST: begin
        w_pll_reset_nxt = 1'b1;
        w_ch_rst_nxt    = '1;
        w_ready_nxt     = 1'b0;
        w_fault_nxt     = 1'b0;
        if (r_cnt == CW'(PLL_RST_CYCLES - 1)) begin
          w_state_nxt     = ST_WAIT_LOCK;
          w_cnt_nxt       = '0;
          w_pll_reset_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_WAIT_LOCK: begin
        w_stable_nxt = w_stable_step;
        w_cnt_nxt    = r_cnt + CW'(1);
        // Stability wins over a timeout landing on the same cycle.
        if (w_stable_step == SW'(LOCK_STABLE_CYCLES)) begin
          w_state_nxt  = ST_RELEASE;
          w_cnt_nxt    = '0;
          w_stable_nxt = '0;
        end else if (r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          w_cnt_nxt       = '0;
          w_stable_nxt    = '0;
          w_pll_reset_nxt = 1'b1;
          if (r_retry == RW'(MAX_RETRIES)) begin
            w_state_nxt = ST_FAULT;
            w_fault_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_PLL_RST;
            w_retry_nxt = r_retry + RW'(1);
          end
        end
      end

      ST_RELEASE: begin
        w_loss_nxt   = w_loss_step;
        w_cnt_nxt    = r_cnt + CW'(1);
        w_ch_rst_nxt = r_ch_rst & ~w_rel_hit;
        if (r_cnt == CW'(REL_LAST)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_ready_nxt = 1'b1;
          w_retry_nxt = '0;
        end
      end

      ST_RUN: begin
        w_loss_nxt = w_loss_step;
      end

      ST_FAULT: begin
        w_pll_reset_nxt = 1'b1;
        w_ch_rst_nxt    = '1;
        w_fault_nxt     = 1'b1;
      end

      default: begin
        w_state_nxt = ST_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase

    // Filtered lock loss while releasing or running restarts the PLL.
    if ((r_state == ST_RELEASE || r_state == ST_RUN) && w_loss_step == LW'(LOSS_FILTER)) begin
      w_state_nxt     = ST_PLL_RST;
      w_cnt_nxt       = '0;
      w_loss_nxt      = '0;
      w_lock_loss_nxt = 1'b1;
      w_pll_reset_nxt = 1'b1;
      w_ch_rst_nxt    = '1;
      w_ready_nxt     = 1'b0;
    end

    if (relock_req_i) begin
      w_state_nxt     = ST_PLL_RST;
      w_cnt_nxt       = '0;
      w_stable_nxt    = '0;
      w_loss_nxt      = '0;
      w_retry_nxt     = '0;
      w_pll_reset_nxt = 1'b1;
      w_ch_rst_nxt    = '1;
      w_ready_nxt     = 1'b0;
      w_fault_nxt     = 1'b0;
      w_lock_loss_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_stable    <= '0;
      r_loss      <= '0;
      r_retry     <= '0;
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_pll_reset <= 1'b1;
      r_ch_rst    <= '1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_loss <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stable    <= w_stable_nxt;
      r_loss      <= w_loss_nxt;
      r_retry     <= w_retry_nxt;
      r_lock_meta <= pll_lock_i;
      r_lock_sync <= r_lock_meta;
      r_pll_reset <= w_pll_reset_nxt;
      r_ch_rst    <= w_ch_rst_nxt;
      r_ready     <= w_ready_nxt;
      r_fault     <= w_fault_nxt;
      r_lock_loss <= w_lock_loss_nxt;
    end
  end

  assign pll_reset_o = r_pll_reset;
  assign ch_rst_o    = r_ch_rst;
  assign ready_o     = r_ready;
  assign fault_o     = r_fault;
  assign lock_loss_o = r_lock_loss;
  assign retry_cnt_o = r_retry;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters; expectations are
// edge counts relative to the last restart edge (rst, relock or lock loss).
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock_i;
  logic       relock_req_i;
  logic       pll_reset_o;
  logic [3:0] ch_rst_o;
  logic       ready_o;
  logic       fault_o;
  logic       lock_loss_o;
  logic [1:0] retry_cnt_o;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .NUM_CH(4), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(64),
    .CH_STAGGER_CYCLES(4), .LOSS_FILTER(3), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock_i(pll_lock_i), .relock_req_i(relock_req_i),
    .pll_reset_o(pll_reset_o), .ch_rst_o(ch_rst_o), .ready_o(ready_o), .fault_o(fault_o),
    .lock_loss_o(lock_loss_o), .retry_cnt_o(retry_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Outputs right after a restart edge.
  task automatic chk_restart(input string tag);
    chk({tag, "_pll_reset"}, 32'(pll_reset_o), 32'd1);
    chk({tag, "_ch_rst"}, 32'(ch_rst_o), 32'hF);
    chk({tag, "_ready"}, 32'(ready_o), 32'd0);
    chk({tag, "_fault"}, 32'(fault_o), 32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt_o), 32'd0);
  endtask

  // Walk a lock-and-release sequence; rel = edge after which RELEASE starts.
  task automatic run_seq(input int rel, input int lock_rise, input int n_max);
    logic [3:0] e_ch;
    for (int n = 1; n <= n_max; n++) begin
      tick();
      for (int i = 0; i < 4; i++) e_ch[i] = (n < rel + 1 + 4 * i);
      chk("seq_pll_reset", 32'(pll_reset_o), 32'(n < 4));
      chk("seq_ch_rst", 32'(ch_rst_o), 32'(e_ch));
      chk("seq_ready", 32'(ready_o), 32'(n >= rel + 14));
      chk("seq_fault", 32'(fault_o), 32'd0);
      chk("seq_lock_loss", 32'(lock_loss_o), 32'd0);
      chk("seq_retry", 32'(retry_cnt_o), 32'd0);
      if (n == lock_rise) pll_lock_i = 1'b1;
    end
  endtask

  task automatic pulse_relock();
    relock_req_i = 1'b1;
    tick();
    relock_req_i = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    pll_lock_i = 1'b0;
    relock_req_i = 1'b0;
    repeat (3) tick();
    chk_restart("reset");
    chk("reset_lock_loss", 32'(lock_loss_o), 32'd0);

    // Power-up: lock rises 10 edges after reset release
    rst = 1'b0;
    run_seq(20, 10, 36);

    // Two-cycle lock dropout is filtered out
    pll_lock_i = 1'b0;
    tick();
    tick();
    pll_lock_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("glitch_ready", 32'(ready_o), 32'd1);
      chk("glitch_lock_loss", 32'(lock_loss_o), 32'd0);
      chk("glitch_ch_rst", 32'(ch_rst_o), 32'h0);
    end

    // Three-cycle dropout is a lock loss
    pll_lock_i = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      if (n == 4) pll_lock_i = 1'b1;
      tick();
      chk("loss_pre_ready", 32'(ready_o), 32'd1);
      chk("loss_pre_pulse", 32'(lock_loss_o), 32'd0);
    end
    tick();
    chk("loss_pulse", 32'(lock_loss_o), 32'd1);
    chk_restart("loss");
    run_seq(12, 0, 28);

    // Relock from RUN, then again mid-RELEASE
    pulse_relock();
    chk_restart("relock_run");
    run_seq(12, 0, 16);
    pulse_relock();
    chk_restart("relock_release");
    run_seq(12, 0, 28);

    // rst after channel 1 released
    pulse_relock();
    chk_restart("relock_pre_rst");
    run_seq(12, 0, 18);
    rst = 1'b1;
    tick();
    chk_restart("mid_rst");
    chk("mid_rst_lock_loss", 32'(lock_loss_o), 32'd0);
    tick();

    // 7-high/1-low lock never qualifies; attempt times out after 64 WAIT_LOCK cycles
    rst = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      pll_lock_i = ((n % 8) != 0);
      tick();
      chk("chop_pll_reset", 32'(pll_reset_o), 32'((n < 4) || (n >= 68)));
      chk("chop_ch_rst", 32'(ch_rst_o), 32'hF);
      chk("chop_ready", 32'(ready_o), 32'd0);
      chk("chop_retry", 32'(retry_cnt_o), 32'(n >= 68));
    end

    // Retry count clears once RUN is reached
    pll_lock_i = 1'b1;
    k = 0;
    while (ready_o !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk("retry_run_ready", 32'(ready_o), 32'd1);
    chk("retry_run_wait", 32'(k), 32'd24);
    chk("retry_run_clear", 32'(retry_cnt_o), 32'd0);

    // No lock at all: three attempts then FAULT
    rst = 1'b1;
    pll_lock_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 254; n++) begin
      tick();
      chk("fault_pll_reset", 32'(pll_reset_o), 32'((n >= 204) || ((n % 68) < 4)));
      chk("fault_retry", 32'(retry_cnt_o), (n >= 136) ? 32'd2 : ((n >= 68) ? 32'd1 : 32'd0));
      chk("fault_fault", 32'(fault_o), 32'(n >= 204));
      chk("fault_ch_rst", 32'(ch_rst_o), 32'hF);
      chk("fault_ready", 32'(ready_o), 32'd0);
    end

    // FAULT ignores lock; relock restarts the full sequence
    pll_lock_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("fault_hold", 32'(fault_o), 32'd1);
      chk("fault_hold_pll_reset", 32'(pll_reset_o), 32'd1);
    end
    pulse_relock();
    chk_restart("relock_fault");
    run_seq(12, 0, 30);
    chk("final_ready", 32'(ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
